neuron_seq: RTL
===============

NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 SHALL have parameter N_IN, default 16, number of terms accumulated per neuron (2..256).
REQ-002 SHALL have parameter STEP_CYC, default 3, clock cycles allotted per accumulate step (1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one neuron evaluation.
REQ-006 SHALL have port abort  input  1  synchronous cancel of the evaluation in progress.
REQ-007 SHALL have port bias  input  8  signed bias, sampled on accepted start.
REQ-008 SHALL have port in_valid / in_ready  input / output  1 / 1  term handshake.
REQ-009 SHALL have port in_data  input  20  signed term (product).
REQ-010 SHALL have port acc_clr  output  1  accumulator loads sign-extended acc_b.
REQ-011 SHALL have port acc_en  output  1  accumulator adds sign-extended acc_din.
REQ-012 SHALL have port acc_din / acc_b  output  20 / 8  operands to the accumulator.
REQ-013 SHALL have port acc_sum  input  24  signed accumulator result.
REQ-014 SHALL have port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-015 SHALL have port result  output  24  neuron output.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, WAIT_IN, STEP, DONE.
REQ-018 IDLE: start=1 -> latch bias into acc_b, go to LOAD; else stay.
REQ-019 LOAD: acc_clr=1 for exactly one cycle; term counter := 0; -> WAIT_IN.
REQ-020 WAIT_IN: in_ready=1; in_valid=1 transfers in_data into acc_din in the same edge -> STEP; else stay, with in_ready held high.
REQ-021 STEP: acc_en=1 on its first cycle only; state holds STEP_CYC cycles total; acc_din stable throughout.
REQ-022 STEP exit: counter == N_IN-1 -> DONE with result latched from acc_sum on exit edge; else counter+1, -> WAIT_IN.
REQ-023 DONE: out_valid=1; result stable until out_valid&out_ready; then -> IDLE, or -> LOAD if start=1 the same cycle, latching the new bias.
REQ-024 in_ready SHALL be 0 in all states except WAIT_IN; in_valid outside WAIT_IN is ignored.
REQ-025 start SHALL be ignored while busy, except as defined in REQ-023.
REQ-026 abort=1 in any state except IDLE -> IDLE next cycle, acc_clr=1 that cycle, out_valid=0, no result update; abort has priority over all other inputs.
REQ-027 acc_clr and acc_en SHALL never be high in the same cycle.
REQ-028 Counter SHALL be ceil(log2(N_IN)) bits and SHALL never wrap within one evaluation.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, acc_b 0, acc_din 0, result 0, and all handshake, busy, acc_clr and acc_en outputs 0.
REQ-030 Reset deassertion mid-evaluation SHALL resume from IDLE only; no partial result is emitted.

Configuration
REQ-031 With NEURON_SEQ_RELU_EN defined, result SHALL be 0 when acc_sum[23]=1, else acc_sum.
REQ-032 Without NEURON_SEQ_RELU_EN, result SHALL equal acc_sum unmodified.

Verification (bench uses a behavioural 24-bit accumulator obeying acc_clr/acc_en)
REQ-033 bias=1, in_data 1..16 with in_valid always high, out_ready=1 -> result=137, out_valid pulses 1 cycle; start-to-out_valid = 2+16*(1+STEP_CYC) cycles (66 at defaults).
REQ-034 bias=-128, all in_data=0 -> result=0 with NEURON_SEQ_RELU_EN; 0xFFFF80 without.
REQ-035 in_valid low for 5 cycles before term 7, out_ready low 4 cycles in DONE -> result still 137; in_ready low throughout STEP; result held steady while stalled.
REQ-036 abort during STEP of term 9 -> IDLE next cycle, acc_clr pulse, no out_valid; a following start with bias=1, in_data 1..16 -> result 137.
REQ-037 rst_n low during WAIT_IN of term 4 -> all outputs 0 asynchronously; start after release -> a correct full evaluation.
REQ-038 start=1 with out_ready=1 in DONE -> next cycle in LOAD, no IDLE cycle; start while busy in WAIT_IN -> no effect.

Source files
------------

// File: rtl/neuron_seq.sv
// Sequencer for one neuron: bias load, N_IN handshaked accumulate steps, result out.
// Define NEURON_SEQ_RELU_EN to clamp negative sums to zero.
module neuron_seq #(
  parameter int N_IN     = 16,
  parameter int STEP_CYC = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_data,
  output logic        acc_clr,
  output logic        acc_en,
  output logic [19:0] acc_din,
  output logic [7:0]  acc_b,
  input  logic [23:0] acc_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] result,
  output logic        busy
);

  localparam int CW = $clog2(N_IN);
  localparam logic [CW-1:0] LAST = CW'(N_IN - 1);
  localparam logic [3:0] SLAST = 4'(STEP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_IN,
    STEP,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    step_cnt;
  logic [23:0]   res_next;

`ifdef NEURON_SEQ_RELU_EN
  assign res_next = acc_sum[23] ? 24'd0 : acc_sum;
`else
  assign res_next = acc_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      step_cnt  <= '0;
      acc_b     <= '0;
      acc_din   <= '0;
      result    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      busy      <= 1'b0;
    end else if (abort && state != IDLE) begin
      // Cancel: clear the accumulator on the first idle cycle.
      state     <= IDLE;
      acc_clr   <= 1'b1;
      acc_en    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      acc_clr <= 1'b0;
      acc_en  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc_b   <= bias;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          cnt      <= '0;
          in_ready <= 1'b1;
          state    <= WAIT_IN;
        end
        WAIT_IN: begin
          if (in_valid) begin
            acc_din  <= in_data;
            acc_en   <= 1'b1;
            in_ready <= 1'b0;
            step_cnt <= '0;
            state    <= STEP;
          end
        end
        STEP: begin
          if (step_cnt == SLAST) begin
            if (cnt == LAST) begin
              result    <= res_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt      <= cnt + 1'b1;
              in_ready <= 1'b1;
              state    <= WAIT_IN;
            end
          end else begin
            step_cnt <= step_cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              acc_b   <= bias;
              acc_clr <= 1'b1;
              state   <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
